keypad_scanner: RTL

Scans a 4x4 matrix keypad by driving one column at a time and sampling the row lines. It synchronizes and debounces the rows, and reports each new key press exactly once. The block sits directly upstream of `keypad_decoder`. Its latched `key_rows`/`key_col` pair feeds the decoder's `rows`/`col` inputs, and `key_valid` tells downstream logic when to capture the decoded `num`.

---
 rtl/keypad_pkg.sv | 12 +
 rtl/keypad_scanner_sync2.sv | 23 ++
 rtl/keypad_scanner.sv | 107 ++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} scan_state_t;

    localparam logic [3:0] COL_FIRST = 4'b0001;

    function automatic logic [3:0] next_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous inputs, cleared by the block reset.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one-shot key reporting.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] col,
    output logic [3:0] key_rows,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
    localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_TICKS - 1);

    scan_state_t   state;
    logic [CW-1:0] scan_cnt;
    logic [CW-1:0] db_cnt;
    logic [3:0]    cand_rows;
    logic [3:0]    rows_s;

    sync2 #(
        .WIDTH (4)
    ) u_sync_rows (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            scan_cnt  <= '0;
            db_cnt    <= '0;
            cand_rows <= '0;
            col       <= COL_FIRST;
            key_rows  <= '0;
            key_col   <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    // Rows are only trusted at the end of the dwell, once the column has settled.
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (rows_s != 4'b0000) begin
                            cand_rows <= rows_s;
                            db_cnt    <= '0;
                            state     <= PRESS_DB;
                        end else begin
                            col <= next_col(col);
                        end
                    end else begin
                        scan_cnt <= scan_cnt + CW'(1);
                    end
                end
                PRESS_DB: begin
                    if (rows_s != cand_rows) begin
                        col      <= next_col(col);
                        scan_cnt <= '0;
                        state    <= SCAN;
                    end else if (db_cnt == DB_LAST) begin
                        key_rows  <= cand_rows;
                        key_col   <= col;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        db_cnt    <= '0;
                        state     <= HELD;
                    end else begin
                        db_cnt <= db_cnt + CW'(1);
                    end
                end
                HELD: begin
                    if ((rows_s & key_rows) == 4'b0000) begin
                        db_cnt <= '0;
                        state  <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if ((rows_s & key_rows) != 4'b0000) begin
                        db_cnt <= '0;
                        state  <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        key_held <= 1'b0;
                        col      <= next_col(col);
                        scan_cnt <= '0;
                        db_cnt   <= '0;
                        state    <= SCAN;
                    end else begin
                        db_cnt <= db_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule
